bytes_decrypter_seq: RTL and testbench
======================================

Name: bytes_decrypter_seq

Overview:
Sequential inverse of bytes_encrypter. It accepts one ciphertext block of number_of_bytes bytes together with the same key and offset used to encrypt it. It recovers the plaintext bytes_per_cycle bytes per clock and signals completion with a one-cycle done pulse. It sits on the receive side of the encrypted-buffer path and feeds plaintext to downstream consumers.

Parameters:
number_of_bytes, 512, block size in bytes; must be a multiple of bytes_per_cycle.
bytes_per_cycle, 8, number of parallel decrypt lanes; must be a power of two, at least 1.

Ports:
clk  input  1  system clock; all logic is on the rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  request to decrypt; sampled only in IDLE.
data_in  input  number_of_bytes*8  ciphertext block; byte i is data_in[8i+7:8i].
key  input  8  cipher key.
offset  input  8  cipher start offset.
busy  output  1  high while in RUN.
done  output  1  one-cycle pulse when data_out is complete.
data_out  output  number_of_bytes*8  plaintext block; byte i is data_out[8i+7:8i].

Behaviour:
- Cipher, fixed team-wide:
  - Encrypt: c[i] = p[i] + key + ((offset + i) mod 256), all mod 256.
  - Decrypt: p[i] = c[i] - key - ((offset + i) mod 256), mod 256.
  - Operands are 8 bit; the carry/borrow is discarded; i is taken mod 256 before the add.
- Reset: state=IDLE, busy=0, done=0, data_out=0, chunk counter=0, latched key/offset/data=0.
- FSM states: IDLE, RUN, DONE.
  - IDLE + start=1: latch data_in, key and offset into internal registers; clear data_out to 0; counter=0; go to RUN.
  - IDLE + start=0: stay in IDLE; all outputs hold.
  - RUN: each cycle decrypt bytes counter*B .. counter*B+B-1 (B = bytes_per_cycle) from the latched block, write them into data_out, then increment the counter.
  - When the chunk just written is the last one (counter = number_of_bytes/B - 1): go to DONE.
  - DONE: done=1 for exactly this one cycle, then go to IDLE unconditionally.
- Latency: done is high during the cycle beginning (number_of_bytes/B)+1 rising edges after the edge that sampled start (65 edges for the defaults). busy is high for exactly number_of_bytes/B cycles.
- data_out is valid from the DONE cycle onward and holds until the next accepted start or reset. During RUN it carries a partial result, and unwritten bytes read 0.
- start is ignored in RUN and in DONE; a start in the DONE cycle is dropped, not queued.
- data_in, key and offset may change freely after the start edge, because the latched copies are used.
- Counter width is clog2(number_of_bytes/B), minimum 1; the counter never wraps within a block.
- Reset asserted in any state (including mid-RUN) takes effect at the next edge: the block returns to the reset values, done is not pulsed, and the partial result is discarded.
- Reset and start in the same cycle: reset wins.

Decomposition:
- Shared package bytes_cipher_pkg holds:
  - BYTE_W = 8.
  - Pure functions encrypt_byte(p, key, offset, idx) and decrypt_byte(c, key, offset, idx).
  - FSM state typedef (IDLE/RUN/DONE).
  - bytes_encrypter is expected to use encrypt_byte so both directions share one definition.
- One combinational sub-module, bytes_decrypt_lane (ports c, key, offset, idx, p), is instantiated bytes_per_cycle times by generate.

Test Plan:
1. number_of_bytes=8, B=2, key=0x00, offset=0x00, data_in all 0x00, pulse start -> data_out bytes 0..7 = 00,FF,FE,FD,FC,FB,FA,F9; done high exactly 5 edges after start; busy high for 4 cycles.
2. number_of_bytes=8, B=2, key=0x10, offset=0xFE, all ciphertext bytes 0x20 -> bytes 0..3 = 12,11,10,0F (checks offset wrap and borrow).
3. Defaults, 512 random bytes encrypted by bytes_encrypter with key=0xA5, offset=0x3C -> data_out equals the original plaintext; done at edge 65.
4. Pulse start again during RUN and also in the DONE cycle -> no restart, a single done pulse, and data_out unchanged after DONE.
5. Assert reset for one cycle at RUN chunk 2 -> next cycle busy=0, done=0, data_out=0. A new start with the scenario 1 inputs then gives the scenario 1 result.
6. Hold data_in, key and offset at new values from the edge after start -> result matches the values latched at the start edge.

Source files
------------

// File: rtl/bytes_cipher_pkg.sv
// Shared byte cipher: c = p + key + (offset + idx), all mod 256.
// Both the encrypter and decrypter use these functions so the two directions cannot drift apart.
package bytes_cipher_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   function automatic logic [BYTE_W-1:0] encrypt_byte(input logic [BYTE_W-1:0] p,
                                                      input logic [BYTE_W-1:0] key,
                                                      input logic [BYTE_W-1:0] offset,
                                                      input logic [BYTE_W-1:0] idx);
      return p + key + (offset + idx);
   endfunction

   function automatic logic [BYTE_W-1:0] decrypt_byte(input logic [BYTE_W-1:0] c,
                                                      input logic [BYTE_W-1:0] key,
                                                      input logic [BYTE_W-1:0] offset,
                                                      input logic [BYTE_W-1:0] idx);
      return c - key - (offset + idx);
   endfunction

endpackage

// File: rtl/bytes_decrypt_lane.sv
// One combinational decrypt lane; idx is the block byte index, already reduced mod 256.
module bytes_decrypt_lane
   import bytes_cipher_pkg::*;
(
   input  logic [BYTE_W-1:0] c,
   input  logic [BYTE_W-1:0] key,
   input  logic [BYTE_W-1:0] offset,
   input  logic [BYTE_W-1:0] idx,
   output logic [BYTE_W-1:0] p
);

   assign p = decrypt_byte(c, key, offset, idx);

endmodule

// File: rtl/bytes_decrypter_seq.sv
// Sequential block decrypter: latches a ciphertext block on start, then recovers
// bytes_per_cycle plaintext bytes per clock and pulses done when data_out is complete.
module bytes_decrypter_seq
   import bytes_cipher_pkg::*;
#(
   parameter int number_of_bytes = 512,
   parameter int bytes_per_cycle = 8
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              start,
   input  logic [number_of_bytes*BYTE_W-1:0] data_in,
   input  logic [BYTE_W-1:0]                 key,
   input  logic [BYTE_W-1:0]                 offset,
   output logic                              busy,
   output logic                              done,
   output logic [number_of_bytes*BYTE_W-1:0] data_out
);

   localparam int W      = number_of_bytes * BYTE_W;
   localparam int CHUNKS = number_of_bytes / bytes_per_cycle;
   localparam int CNT_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
   localparam int LOG_B  = $clog2(bytes_per_cycle);

   state_t                                      state, state_next;
   logic [CNT_W-1:0]                            cnt;
   logic [W-1:0]                                data_q;
   logic [BYTE_W-1:0]                           key_q, offset_q;
   logic [31:0]                                 base;
   logic                                        last, accept;
   logic [bytes_per_cycle-1:0][BYTE_W-1:0]      lane_c, lane_idx, lane_p;

   assign base = 32'(cnt) << LOG_B;
   assign last = (cnt == CNT_W'(CHUNKS - 1));
   // done high marks the post-DONE cycle; blocking start there keeps a late start from being queued
   assign accept = (state == IDLE) && start && !done;

   for (genvar j = 0; j < bytes_per_cycle; j++) begin : g_lane
      assign lane_c[j]   = data_q[(base + 32'(j)) * BYTE_W +: BYTE_W];
      assign lane_idx[j] = 8'(base + 32'(j));

      bytes_decrypt_lane u_lane (
         .c      (lane_c[j]),
         .key    (key_q),
         .offset (offset_q),
         .idx    (lane_idx[j]),
         .p      (lane_p[j])
      );
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = RUN;
         RUN:     if (last) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         data_out <= '0;
         cnt      <= '0;
         data_q   <= '0;
         key_q    <= '0;
         offset_q <= '0;
      end else begin
         state <= state_next;
         busy  <= (state == RUN);
         done  <= (state == DONE);
         case (state)
            IDLE: begin
               if (accept) begin
                  data_q   <= data_in;
                  key_q    <= key;
                  offset_q <= offset;
                  data_out <= '0;
                  cnt      <= '0;
               end
            end
            RUN: begin
               for (int unsigned j = 0; j < bytes_per_cycle; j++)
                  data_out[(base + j) * BYTE_W +: BYTE_W] <= lane_p[j];
               if (!last) cnt <= cnt + CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_bytes_decrypter_seq.sv
// Directed bench: small (8 bytes, 2 lanes) and default (512 bytes, 8 lanes) decrypters.
module tb_bytes_decrypter_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset;
   logic          s_start, s_busy, s_done;
   logic [63:0]   s_din, s_dout;
   logic [7:0]    s_key, s_off;
   logic          l_start, l_busy, l_done;
   logic [4095:0] l_din, l_dout;
   logic [7:0]    l_key, l_off;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [7:0]  key;
      logic [7:0]  off;
      logic [63:0] c;
      logic [63:0] p;
   } vec_t;

   vec_t vecs[5];

   bytes_decrypter_seq #(.number_of_bytes(8), .bytes_per_cycle(2)) dut_s (
      .clk(clk), .reset(reset), .start(s_start), .data_in(s_din), .key(s_key),
      .offset(s_off), .busy(s_busy), .done(s_done), .data_out(s_dout)
   );

   bytes_decrypter_seq dut_l (
      .clk(clk), .reset(reset), .start(l_start), .data_in(l_din), .key(l_key),
      .offset(l_off), .busy(l_busy), .done(l_done), .data_out(l_dout)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] enc(input logic [7:0] p, input logic [7:0] k,
                                      input logic [7:0] o, input int i);
      logic [7:0] ii;
      ii = 8'(i);
      return p + k + o + ii;
   endfunction

   // Start one block, scramble inputs right after the start edge, optionally poke start in RUN and in the done cycle.
   task automatic run_small(input vec_t v, input bit poke, input string tag);
      int done_at = 0;
      int dones   = 0;
      int busy_n  = 0;
      s_din   = v.c;
      s_key   = v.key;
      s_off   = v.off;
      s_start = 1'b1;
      tick();
      s_start = 1'b0;
      s_din   = ~v.c;
      s_key   = v.key ^ 8'h5A;
      s_off   = v.off + 8'd77;
      for (int n = 1; n <= 12; n++) begin
         tick();
         if (s_busy) busy_n++;
         if (s_done) begin
            dones++;
            if (done_at == 0) done_at = n;
         end
         s_start = poke && (n == 2 || n == 5);
      end
      s_start = 1'b0;
      check($sformatf("%s_done_edge", tag), 64'(done_at), 64'd5);
      check($sformatf("%s_done_count", tag), 64'(dones), 64'd1);
      check($sformatf("%s_busy_cycles", tag), 64'(busy_n), 64'd4);
      check($sformatf("%s_data", tag), s_dout, v.p);
   endtask

   initial begin
      logic [7:0] plain [512];
      int done_at, dones, busy_n, miss;

      vecs[0] = '{key: 8'h00, off: 8'h00, c: 64'h0000000000000000, p: 64'hF9FAFBFCFDFEFF00};
      vecs[1] = '{key: 8'h10, off: 8'hFE, c: 64'h2020202020202020, p: 64'h0B0C0D0E0F101112};
      vecs[2] = '{key: 8'h01, off: 8'h00, c: 64'h0807060504030201, p: 64'h0000000000000000};
      vecs[3] = '{key: 8'hFF, off: 8'h80, c: 64'hFFFFFFFFFFFFFFFF, p: 64'h797A7B7C7D7E7F80};
      vecs[4] = '{key: 8'h33, off: 8'h10, c: 64'h0123456789ABCDEF, p: 64'hB7DAFD20436689AC};

      reset = 1'b1;
      s_start = 1'b0; s_din = '0; s_key = '0; s_off = '0;
      l_start = 1'b0; l_din = '0; l_key = '0; l_off = '0;
      tick();
      tick();
      check("rst_s_busy", 64'(s_busy), 64'd0);
      check("rst_s_done", 64'(s_done), 64'd0);
      check("rst_s_data", s_dout, 64'd0);
      check("rst_l_busy", 64'(l_busy), 64'd0);
      check("rst_l_done", 64'(l_done), 64'd0);
      check("rst_l_data_zero", 64'(l_dout == '0), 64'd1);
      reset = 1'b0;
      tick();

      for (int i = 0; i < 5; i++)
         run_small(vecs[i], i == 1, $sformatf("vec%0d", i));

      // Reset while chunk 2 is being decrypted
      s_din = vecs[4].c; s_key = vecs[4].key; s_off = vecs[4].off;
      s_start = 1'b1;
      tick();
      s_start = 1'b0;
      tick();
      tick();
      check("midrun_busy_before", 64'(s_busy), 64'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("midrun_rst_busy", 64'(s_busy), 64'd0);
      check("midrun_rst_done", 64'(s_done), 64'd0);
      check("midrun_rst_data", s_dout, 64'd0);
      dones = 0;
      for (int n = 0; n < 8; n++) begin
         tick();
         if (s_done) dones++;
      end
      check("midrun_no_done", 64'(dones), 64'd0);
      run_small(vecs[0], 1'b0, "after_rst");

      // Full-size block
      for (int i = 0; i < 512; i++) begin
         plain[i] = 8'($urandom_range(0, 255));
         l_din[8*i +: 8] = enc(plain[i], 8'hA5, 8'h3C, i);
      end
      l_key = 8'hA5; l_off = 8'h3C; l_start = 1'b1;
      tick();
      l_start = 1'b0; l_din = ~l_din; l_key = 8'h00; l_off = 8'h00;
      done_at = 0; dones = 0; busy_n = 0;
      for (int n = 1; n <= 80; n++) begin
         tick();
         if (l_busy) busy_n++;
         if (l_done) begin
            dones++;
            if (done_at == 0) done_at = n;
         end
      end
      check("big_done_edge", 64'(done_at), 64'd65);
      check("big_done_count", 64'(dones), 64'd1);
      check("big_busy_cycles", 64'(busy_n), 64'd64);
      miss = 0;
      for (int i = 0; i < 512; i++)
         if (l_dout[8*i +: 8] !== plain[i]) miss++;
      check("big_data_mismatches", 64'(miss), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
